// File: rtl/rc4_pkg.sv
// Constants and checker state encodings shared by the RC4 decryption core,
// the plaintext checker and the key-search controller.
package rc4_pkg;

  localparam int MSG_LEN = 32;

  localparam logic [7:0] CHAR_LO = 8'h61;
  localparam logic [7:0] CHAR_HI = 8'h7A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } chk_state_e;

endpackage

// File: rtl/char_accept.sv
// Combinational plaintext filter: accepts bytes in [CHAR_LO, CHAR_HI] or CHAR_SP.
module char_accept #(
  parameter logic [7:0] CHAR_LO = rc4_pkg::CHAR_LO,
  parameter logic [7:0] CHAR_HI = rc4_pkg::CHAR_HI,
  parameter logic [7:0] CHAR_SP = rc4_pkg::CHAR_SP
) (
  input  logic [7:0] data_in,
  output logic       accept
);

  assign accept = ((data_in >= CHAR_LO) && (data_in <= CHAR_HI)) || (data_in == CHAR_SP);

endmodule

// File: rtl/plaintext_checker.sv
// Scans the decrypted-message RAM and reports whether every byte is plausible
// plaintext, with the index of the first rejected byte.
module plaintext_checker
  import rc4_pkg::*;
#(
  parameter int         MSG_LEN = rc4_pkg::MSG_LEN,
  parameter int         ADDR_W  = 8,
  parameter logic [7:0] CHAR_LO = rc4_pkg::CHAR_LO,
  parameter logic [7:0] CHAR_HI = rc4_pkg::CHAR_HI,
  parameter logic [7:0] CHAR_SP = rc4_pkg::CHAR_SP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_sig,
  input  logic [7:0]        aOut,
  output logic [ADDR_W-1:0] aAddr,
  output logic              check_finished,
  output logic              msg_valid,
  output logic [ADDR_W-1:0] fail_index,
  output logic [2:0]        stateTap
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

  chk_state_e        state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        byte_q, byte_d;
  logic              msg_valid_q, msg_valid_d;
  logic [ADDR_W-1:0] fail_index_q, fail_index_d;
  logic              byte_ok;

  char_accept #(
    .CHAR_LO(CHAR_LO),
    .CHAR_HI(CHAR_HI),
    .CHAR_SP(CHAR_SP)
  ) u_char_accept (
    .data_in(byte_q),
    .accept (byte_ok)
  );

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    addr_d       = addr_q;
    byte_d       = byte_q;
    msg_valid_d  = msg_valid_q;
    fail_index_d = fail_index_q;
    case (state_q)
      ST_IDLE: begin
        if (start_sig) begin
          state_d      = ST_READ;
          index_d      = '0;
          addr_d       = '0;
          msg_valid_d  = 1'b0;
          fail_index_d = '0;
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        byte_d  = aOut;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!byte_ok) begin
          msg_valid_d  = 1'b0;
          fail_index_d = index_q;
          state_d      = ST_DONE;
        end else if (index_q == LAST_IDX) begin
          msg_valid_d  = 1'b1;
          fail_index_d = '0;
          state_d      = ST_DONE;
        end else begin
          // Address is registered on entry to READ so the RAM data lands in WAIT.
          index_d = index_q + ADDR_W'(1);
          addr_d  = index_q + ADDR_W'(1);
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        if (!start_sig) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      index_q      <= '0;
      addr_q       <= '0;
      byte_q       <= '0;
      msg_valid_q  <= 1'b0;
      fail_index_q <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      addr_q       <= addr_d;
      byte_q       <= byte_d;
      msg_valid_q  <= msg_valid_d;
      fail_index_q <= fail_index_d;
    end
  end

  assign aAddr          = addr_q;
  assign check_finished = (state_q == ST_DONE);
  assign msg_valid      = msg_valid_q;
  assign fail_index     = fail_index_q;
  assign stateTap       = state_q;

endmodule

// File: tb/tb_plaintext_checker.sv
// Directed testbench for plaintext_checker with a 1-cycle-latency RAM model.
module tb_plaintext_checker;

  logic       clk;
  logic       reset;
  logic       start_sig;
  logic [7:0] aOut;
  logic [7:0] aAddr;
  logic       check_finished;
  logic       msg_valid;
  logic [7:0] fail_index;
  logic [2:0] stateTap;

  logic [7:0] mem [0:255];
  int         visits [0:255];
  int         first_addr;
  int         max_addr;
  int         checks;
  int         errors;

  plaintext_checker dut (
    .clk           (clk),
    .reset         (reset),
    .start_sig     (start_sig),
    .aOut          (aOut),
    .aAddr         (aAddr),
    .check_finished(check_finished),
    .msg_valid     (msg_valid),
    .fail_index    (fail_index),
    .stateTap      (stateTap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) aOut <= mem[aAddr];

  task automatic fill(input logic [7:0] b);
    for (int i = 0; i < 256; i++) mem[i] = b;
  endtask

  // Start must already be high; the next posedge is edge 0. Returns the edge
  // after which check_finished was first seen, or -1 on timeout.
  task automatic run_until_done(output int edges);
    for (int i = 0; i < 256; i++) visits[i] = 0;
    first_addr = -1;
    max_addr   = -1;
    edges      = -1;
    for (int e = 0; e < 300; e++) begin
      @(posedge clk);
      #1;
      if (stateTap == 3'd1) begin
        visits[aAddr]++;
        if (first_addr < 0) first_addr = int'(aAddr);
        if (int'(aAddr) > max_addr) max_addr = int'(aAddr);
      end
      if (check_finished) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic return_to_idle();
    @(negedge clk);
    start_sig = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_sig = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({aAddr, check_finished, msg_valid, fail_index, stateTap} !== 21'd0) begin
      errors++;
      $display("FAIL reset_values: got aAddr=%0d fin=%b valid=%b fidx=%0d state=%0d, want all 0",
               aAddr, check_finished, msg_valid, fail_index, stateTap);
    end
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_all_valid();
    int edges;
    int bad_visits;
    fill(8'h61);
    @(negedge clk);
    start_sig = 1'b1;
    run_until_done(edges);
    bad_visits = 0;
    for (int i = 0; i < 32; i++) if (visits[i] != 1) bad_visits++;
    for (int i = 32; i < 256; i++) if (visits[i] != 0) bad_visits++;
    checks++;
    if (edges != 96) begin
      errors++;
      $display("FAIL all_valid_latency: got edge %0d, want 96", edges);
    end
    checks++;
    if (msg_valid !== 1'b1 || fail_index !== 8'd0) begin
      errors++;
      $display("FAIL all_valid_verdict: got valid=%b fidx=%0d, want valid=1 fidx=0", msg_valid, fail_index);
    end
    checks++;
    if (bad_visits != 0 || first_addr != 0) begin
      errors++;
      $display("FAIL all_valid_addr_visits: got %0d bad addresses first=%0d, want 0 bad first=0", bad_visits, first_addr);
    end
    $display("test_all_valid: edges=%0d valid=%b fidx=%0d", edges, msg_valid, fail_index);
    return_to_idle();
  endtask

  task automatic test_early_fail();
    int edges;
    fill(8'h7A);
    mem[5] = 8'h41;
    @(negedge clk);
    start_sig = 1'b1;
    run_until_done(edges);
    checks++;
    if (edges != 18) begin
      errors++;
      $display("FAIL early_fail_latency: got edge %0d, want 18", edges);
    end
    checks++;
    if (msg_valid !== 1'b0 || fail_index !== 8'd5) begin
      errors++;
      $display("FAIL early_fail_verdict: got valid=%b fidx=%0d, want valid=0 fidx=5", msg_valid, fail_index);
    end
    checks++;
    if (max_addr != 5) begin
      errors++;
      $display("FAIL early_fail_max_addr: got %0d, want 5", max_addr);
    end
    $display("test_early_fail: edges=%0d valid=%b fidx=%0d max_addr=%0d", edges, msg_valid, fail_index, max_addr);
    return_to_idle();
  endtask

  task automatic test_boundaries();
    int edges;
    // space at 0, 'z' at 31: accepted
    fill(8'h61);
    mem[0]  = 8'h20;
    mem[31] = 8'h7A;
    @(negedge clk);
    start_sig = 1'b1;
    run_until_done(edges);
    checks++;
    if (edges != 96 || msg_valid !== 1'b1 || fail_index !== 8'd0) begin
      errors++;
      $display("FAIL boundary_space_z: got edge=%0d valid=%b fidx=%0d, want 96/1/0", edges, msg_valid, fail_index);
    end
    $display("test_boundaries space/z: edges=%0d valid=%b fidx=%0d", edges, msg_valid, fail_index);
    return_to_idle();
    // backtick just below 'a' at 0
    fill(8'h61);
    mem[0] = 8'h60;
    @(negedge clk);
    start_sig = 1'b1;
    run_until_done(edges);
    checks++;
    if (edges != 3 || msg_valid !== 1'b0 || fail_index !== 8'd0) begin
      errors++;
      $display("FAIL boundary_0x60: got edge=%0d valid=%b fidx=%0d, want 3/0/0", edges, msg_valid, fail_index);
    end
    $display("test_boundaries 0x60@0: edges=%0d valid=%b fidx=%0d", edges, msg_valid, fail_index);
    return_to_idle();
    // '{' just above 'z' at the last index
    fill(8'h61);
    mem[31] = 8'h7B;
    @(negedge clk);
    start_sig = 1'b1;
    run_until_done(edges);
    checks++;
    if (edges != 96 || msg_valid !== 1'b0 || fail_index !== 8'd31) begin
      errors++;
      $display("FAIL boundary_0x7B: got edge=%0d valid=%b fidx=%0d, want 96/0/31", edges, msg_valid, fail_index);
    end
    $display("test_boundaries 0x7B@31: edges=%0d valid=%b fidx=%0d", edges, msg_valid, fail_index);
    return_to_idle();
  endtask

  task automatic test_handshake();
    int edges;
    int drops;
    int reads;
    fill(8'h61);
    @(negedge clk);
    start_sig = 1'b1;
    run_until_done(edges);
    drops = 0;
    reads = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (check_finished !== 1'b1) drops++;
      if (stateTap == 3'd1) reads++;
    end
    checks++;
    if (drops != 0 || reads != 0) begin
      errors++;
      $display("FAIL hold_done: got %0d drops %0d reads, want 0 and 0", drops, reads);
    end
    $display("test_handshake hold: drops=%0d reads=%0d", drops, reads);
    return_to_idle();
    checks++;
    if (check_finished !== 1'b0 || stateTap !== 3'd0 || msg_valid !== 1'b1) begin
      errors++;
      $display("FAIL drop_start: got fin=%b state=%0d valid=%b, want 0/0/1", check_finished, stateTap, msg_valid);
    end
    $display("test_handshake drop: fin=%b state=%0d valid=%b", check_finished, stateTap, msg_valid);
    mem[3] = 8'h2E;
    @(negedge clk);
    start_sig = 1'b1;
    run_until_done(edges);
    checks++;
    if (first_addr != 0 || edges != 12 || fail_index !== 8'd3 || msg_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart: got first=%0d edge=%0d fidx=%0d valid=%b, want 0/12/3/0",
               first_addr, edges, fail_index, msg_valid);
    end
    $display("test_handshake restart: first=%0d edges=%0d fidx=%0d", first_addr, edges, fail_index);
    return_to_idle();
  endtask

  task automatic test_reset_mid_check();
    int edges;
    bit found;
    fill(8'h61);
    found = 0;
    @(negedge clk);
    start_sig = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (stateTap == 3'd1 && aAddr == 8'd10) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_index10: got no READ at 10, want READ at 10");
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({aAddr, check_finished, msg_valid, fail_index, stateTap} !== 21'd0) begin
      errors++;
      $display("FAIL mid_reset_values: got aAddr=%0d fin=%b valid=%b fidx=%0d state=%0d, want all 0",
               aAddr, check_finished, msg_valid, fail_index, stateTap);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_until_done(edges);
    checks++;
    if (first_addr != 0 || edges != 96 || msg_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_restart: got first=%0d edge=%0d valid=%b, want 0/96/1", first_addr, edges, msg_valid);
    end
    $display("test_reset_mid_check: first=%0d edges=%0d valid=%b", first_addr, edges, msg_valid);
    return_to_idle();
  endtask

  task automatic test_pulse_start();
    int fin_edge;
    int fin_cycles;
    fill(8'h7A);
    fin_edge = -1;
    fin_cycles = 0;
    @(negedge clk);
    start_sig = 1'b1;
    @(posedge clk);
    #1;
    start_sig = 1'b0;
    for (int e = 1; e < 120; e++) begin
      @(posedge clk);
      #1;
      if (check_finished) begin
        fin_cycles++;
        if (fin_edge < 0) fin_edge = e;
      end
    end
    checks++;
    if (fin_edge != 96 || fin_cycles != 1) begin
      errors++;
      $display("FAIL pulse_start: got edge=%0d cycles=%0d, want 96 and 1", fin_edge, fin_cycles);
    end
    checks++;
    if (stateTap !== 3'd0 || msg_valid !== 1'b1) begin
      errors++;
      $display("FAIL pulse_idle: got state=%0d valid=%b, want 0 and 1", stateTap, msg_valid);
    end
    $display("test_pulse_start: edge=%0d cycles=%0d state=%0d", fin_edge, fin_cycles, stateTap);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start_sig = 1'b0;
    fill(8'h00);
    test_reset();
    test_all_valid();
    test_early_fail();
    test_boundaries();
    test_handshake();
    test_reset_mid_check();
    test_pulse_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plaintext_checker.md
Name: plaintext_checker

Overview:
Reads back the decrypted-message RAM that the RC4 decryption core fills, and decides whether the result is plausible plaintext. Every byte must be lowercase ASCII 'a'..'z' or space. The block sits beside the decryption core on the same RAM port, which is muxed by the top level. It gives the key-search controller a pass/fail verdict plus the first offending index. Its start/finished handshake is level-based, matching the decryption core's, so the controller can chain the two blocks.

Parameters:
MSG_LEN, 32, number of message bytes checked (indices 0..MSG_LEN-1)
ADDR_W, 8, width of the decrypted-RAM address bus
CHAR_LO, 8'h61, lowest accepted letter ('a')
CHAR_HI, 8'h7A, highest accepted letter ('z')
CHAR_SP, 8'h20, additionally accepted byte (space)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start_sig  input  1  level request; sampled in IDLE
aOut  input  8  read data from the decrypted RAM, valid one cycle after aAddr is registered
aAddr  output  ADDR_W  read address to the decrypted RAM
check_finished  output  1  verdict ready; held high while start_sig stays high
msg_valid  output  1  1 = all MSG_LEN bytes accepted; meaningful when check_finished=1
fail_index  output  ADDR_W  index of the first rejected byte; 0 when msg_valid=1
stateTap  output  3  current FSM state encoding, for debug

Behaviour:
- Reset: asynchronous, active-high; clk is the single clock.
  - Reset drives state to IDLE and clears the internal index.
  - Reset values: aAddr=0, check_finished=0, msg_valid=0, fail_index=0, stateTap=IDLE.
  - Reset mid-check aborts immediately. No verdict is produced.
- FSM states and encodings: IDLE=0, READ=1, WAIT=2, CHECK=3, DONE=4.
- IDLE:
  - If start_sig=1 at the clock edge: go to READ, index:=0, msg_valid:=0, fail_index:=0.
  - Otherwise stay in IDLE.
- READ: aAddr=index (registered output). Go to WAIT.
- WAIT: the RAM presents aOut. The byte is captured into an internal register at the edge leaving WAIT. Go to CHECK.
- CHECK: the captured byte is accepted if (CHAR_LO <= byte <= CHAR_HI) or byte == CHAR_SP, using unsigned compares.
  - Rejected byte: msg_valid:=0, fail_index:=index, go to DONE. This is an early exit; no further addresses are issued.
  - Accepted and index==MSG_LEN-1: msg_valid:=1, fail_index:=0, go to DONE.
  - Accepted otherwise: index:=index+1, go to READ.
- Index register is ADDR_W wide. It never wraps, because the terminal compare is at MSG_LEN-1. MSG_LEN must be <= 2**ADDR_W.
- DONE:
  - check_finished=1; msg_valid and fail_index are held stable.
  - Stay while start_sig=1.
  - start_sig=0 at the edge: go to IDLE, and check_finished drops on that same edge.
  - msg_valid and fail_index keep their values in IDLE until the next accepted start.
- Latency: 3 cycles per byte, taking edge 0 as the edge that samples start_sig.
  - All-valid message: check_finished rises after edge 3*MSG_LEN (edge 96 for the default).
  - Rejection at byte k: check_finished rises after edge 3*(k+1).
- No restart without a handshake: start_sig held high through DONE does not retrigger a check. It must go low for at least one edge, then high again.
- start_sig dropping while in READ, WAIT or CHECK is ignored. The check runs to completion, then DONE exits on the next edge that sees start_sig=0.
- aAddr holds its last value outside READ and is not required to return to 0.
- The block has no write port. It never writes the RAM.

Decomposition:
- Shared package (rc4_pkg):
  - the checker state enum and its encodings;
  - CHAR_LO, CHAR_HI and CHAR_SP defaults;
  - MSG_LEN, also used by the decryption core and the key-search controller.
- One natural sub-module: char_accept. It is purely combinational: 8-bit byte in, 1-bit accept out, parameterised by the three character constants. The key-search controller reuses it for per-byte early abort.

Test Plan:
- RAM model with 1-cycle read latency, preloaded with 32 bytes of 8'h61; start held high -> check_finished=1 after edge 96, msg_valid=1, fail_index=0, aAddr visits 0..31 exactly once each.
- Byte 5 = 8'h41 ('A'), rest 'z' -> check_finished after edge 18, msg_valid=0, fail_index=5, aAddr never exceeds 5.
- Boundary bytes, one run each:
  - 8'h20 at index 0 and 8'h7A at index 31 -> valid.
  - 8'h60 at index 0 -> fail_index=0 after edge 3.
  - 8'h7B at index 31 -> fail_index=31.
- Handshake:
  - Hold start_sig high 50 cycles past DONE -> check_finished stays 1, no new reads.
  - Drop start_sig -> check_finished=0 after the next edge; msg_valid unchanged.
  - Raise start_sig again -> a fresh check starts at index 0.
- Assert reset for 2 cycles while index=10 -> all outputs return to reset values immediately; after release with start_sig high, a full check restarts from aAddr=0.
- Pulse start_sig for 1 cycle only -> check completes; DONE lasts one cycle, so check_finished pulses for 1 cycle and the FSM returns to IDLE.
